pwm_timebase_3b: RTL and testbench
==================================

// Module: pwm_timebase_3b
// PURPOSE
//   Timebase and duty-compare stage of the 3-bit PWM generator.
//   Runs a prescaled 3-bit period counter whose value and enable drive the 3x8 one-hot decoder directly.
//   Holds a shadowed duty register so duty updates are glitch-free.
//   Produces the PWM output and a period-boundary strobe.
// PARAMETERS
//   PRESC_W  4  width of prescaler divide value and internal prescale counter
// PORTS
//   clk          in   1        single system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   run          in   1        1 = generate PWM; 0 = stop at end of current period
//   presc_div    in   PRESC_W  counter advances every (presc_div+1) clk cycles
//   duty_in      in   3        new duty value, high count per 8-step period
//   duty_wr      in   1        1-cycle strobe; captures duty_in into shadow register
//   cnt          out  3        period counter; feeds decoder select input
//   dec_en       out  1        decoder enable; high whenever state != IDLE
//   pwm_out      out  1        PWM waveform
//   period_tick  out  1        1-cycle pulse, period wrap
//   duty_active  out  3        duty value applied to the current period
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, cnt=0, presc_cnt=0, duty_shadow=0, duty_active=0.
//     Outputs during reset: pwm_out=0, dec_en=0, period_tick=0.
//   FSM states: IDLE, RUN, STOP_PEND.
//     IDLE -> RUN when run=1. On that edge: duty_active<=duty_shadow, cnt=0, presc_cnt=0.
//     RUN -> STOP_PEND when run=0.
//     STOP_PEND -> RUN when run=1. No restart; counting continues.
//     STOP_PEND -> IDLE on the edge where cnt wraps 7->0. cnt and presc_cnt are left at 0.
//   Prescaler, active only in RUN or STOP_PEND:
//     tick = (presc_cnt >= presc_div).
//     On tick: presc_cnt<=0 and cnt<=cnt+1, mod 8 (7 wraps to 0). Otherwise presc_cnt increments.
//     The >= compare means lowering presc_div mid-count produces a tick on the next cycle with no long wait.
//     presc_div=0 advances cnt every cycle.
//   IDLE: cnt and presc_cnt held at 0; ticks are ignored.
//   Period boundary = tick with cnt==7 in RUN or STOP_PEND. On that edge:
//     - cnt<=0 and duty_active<=duty_shadow.
//     - period_tick is registered high for exactly the following cycle.
//   duty_wr: duty_shadow<=duty_in on the edge it is sampled; allowed in any state.
//     If duty_wr coincides with the boundary edge, duty_active takes the OLD shadow value (no bypass).
//     The new value applies from the next period.
//   pwm_out = (state != IDLE) && (cnt < duty_active). Combinational from registers only.
//     No path from inputs, so it is glitch-free.
//     duty 0 gives constant 0; duty 7 gives 7 of 8 steps high. 100% duty is not supported.
//   dec_en = (state != IDLE). The decoder therefore outputs all-zero when idle.
//   Latency: duty write to effect is 1 to 8 counter steps (applied at the next boundary).
//     Change of run to state change is 1 clk.
// TESTING
//   1. Reset, then presc_div=0, duty_wr with duty_in=3, run=1.
//      -> From the cycle after run is sampled, pwm_out repeats 1,1,1,0,0,0,0,0.
//      -> period_tick pulses every 8 clk; dec_en=1.
//   2. presc_div=1, duty=5.
//      -> cnt holds each value for 2 clk; period is 16 clk; pwm_out is high 10 clk, low 6 clk.
//   3. Running with duty=2; duty_wr with duty_in=6 while cnt=3.
//      -> The current period stays 2 high; the next period is 6 high.
//      -> duty_active changes exactly on the wrap edge.
//   4. duty_wr with duty_in=4 on the same edge as the 7->0 wrap.
//      -> The next period uses the old duty; the period after that uses 4.
//   5. run dropped at cnt=2.
//      -> Counting continues through cnt=7, then IDLE with cnt=0, dec_en=0, pwm_out=0.
//      -> If run is re-raised at cnt=5 (STOP_PEND), there is no gap and no restart.
//   6. rst_n pulsed low mid-period with cnt=4 and pwm_out=1.
//      -> All outputs go to 0 immediately (asynchronous); after release, state is IDLE.
//      -> duty_shadow=0, so restarting without a duty_wr gives pwm_out constant 0.

Source files
------------

// File: rtl/pwm_timebase_3b.sv
// Timebase and duty-compare stage of the 3-bit PWM generator.
// A prescaled 3-bit period counter drives the downstream 3x8 decoder directly.
// The duty register is double-buffered: writes land in a shadow copy, and
// that copy is promoted only at a period boundary, so the waveform never glitches.
module pwm_timebase_3b #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [2:0]         duty_in,
    input  logic               duty_wr,
    output logic [2:0]         cnt,
    output logic               dec_en,
    output logic               pwm_out,
    output logic               period_tick,
    output logic [2:0]         duty_active
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopPend = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [2:0]         duty_shadow_q, duty_shadow_d;
    logic [2:0]         duty_active_q, duty_active_d;
    logic               period_tick_q, period_tick_d;

    logic               tick;
    logic               boundary;

    // Prescaler compare and period-boundary detection.
    // The >= compare lets a lowered divide value take effect on the next cycle.
    always_comb begin
        tick     = (presc_cnt_q >= presc_div);
        boundary = (state_q != StIdle) && tick && (cnt_q == 3'd7);
    end

    // Next-state logic for the FSM, counters and duty registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        presc_cnt_d   = presc_cnt_q;
        duty_active_d = duty_active_q;
        period_tick_d = 1'b0;

        // Shadow write is accepted in any state; the active copy reads the old value below.
        duty_shadow_d = duty_wr ? duty_in : duty_shadow_q;

        unique case (state_q)
            StIdle: begin
                cnt_d       = 3'd0;
                presc_cnt_d = '0;
                if (run) begin
                    state_d       = StRun;
                    duty_active_d = duty_shadow_q;
                end
            end
            StRun, StStopPend: begin
                if (tick) begin
                    presc_cnt_d = '0;
                    cnt_d       = cnt_q + 3'd1;
                end else begin
                    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
                end

                if (boundary) begin
                    duty_active_d = duty_shadow_q;
                    period_tick_d = 1'b1;
                end

                if (state_q == StRun) begin
                    if (!run) begin
                        state_d = StStopPend;
                    end
                end else begin
                    // Re-raising run resumes without restarting the period.
                    if (run) begin
                        state_d = StRun;
                    end else if (boundary) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                cnt_d       = 3'd0;
                presc_cnt_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 3'd0;
            presc_cnt_q   <= '0;
            duty_shadow_q <= 3'd0;
            duty_active_q <= 3'd0;
            period_tick_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            presc_cnt_q   <= presc_cnt_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            period_tick_q <= period_tick_d;
        end
    end

    // Outputs are decoded from registers only, so no input can glitch them.
    always_comb begin
        cnt         = cnt_q;
        dec_en      = (state_q != StIdle);
        pwm_out     = (state_q != StIdle) && (cnt_q < duty_active_q);
        period_tick = period_tick_q;
        duty_active = duty_active_q;
    end

endmodule

// File: tb/tb_pwm_timebase_3b.sv
// Bench for pwm_timebase_3b: a behavioural model checked on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_timebase_3b;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] presc_div;
    logic [2:0] duty_in;
    logic       duty_wr;
    logic [2:0] cnt;
    logic       dec_en;
    logic       pwm_out;
    logic       period_tick;
    logic [2:0] duty_active;

    int total = 0;
    int bad   = 0;

    // Behavioural model: running flag, stopping flag, step position, cycles spent on the step.
    bit m_on     = 1'b0;
    bit m_stop   = 1'b0;
    bit m_tick   = 1'b0;
    int m_cnt    = 0;
    int m_wait   = 0;
    int m_shadow = 0;
    int m_active = 0;

    pwm_timebase_3b #(
        .PRESC_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .presc_div  (presc_div),
        .duty_in    (duty_in),
        .duty_wr    (duty_wr),
        .cnt        (cnt),
        .dec_en     (dec_en),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .duty_active(duty_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the next rising edge will sample.
    task model_step();
        bit wrapped;
        wrapped = 1'b0;
        m_tick  = 1'b0;
        if (!m_on) begin
            if (run) begin
                m_on     = 1'b1;
                m_stop   = 1'b0;
                m_cnt    = 0;
                m_wait   = 0;
                m_active = m_shadow;
            end
        end else begin
            // A step lasts presc_div+1 cycles; wait counts cycles already spent on it.
            if (m_wait >= int'(presc_div)) begin
                m_wait = 0;
                m_cnt  = (m_cnt + 1) % 8;
                if (m_cnt == 0) begin
                    wrapped  = 1'b1;
                    m_active = m_shadow;
                    m_tick   = 1'b1;
                end
            end else begin
                m_wait = m_wait + 1;
            end
            if (m_stop) begin
                if (run) m_stop = 1'b0;
                else if (wrapped) m_on = 1'b0;
            end else if (!run) begin
                m_stop = 1'b1;
            end
        end
        if (duty_wr) m_shadow = int'(duty_in);
    endtask

    // Compare process: every falling edge, check outputs against the model, then advance it.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_on = 1'b0; m_stop = 1'b0; m_tick = 1'b0;
                m_cnt = 0; m_wait = 0; m_shadow = 0; m_active = 0;
            end
            check("model_cnt", int'(cnt), m_cnt);
            check("model_dec_en", int'(dec_en), int'(m_on));
            check("model_pwm", int'(pwm_out), (m_on && (m_cnt < m_active)) ? 1 : 0);
            check("model_tick", int'(period_tick), int'(m_tick));
            check("model_duty_active", int'(duty_active), m_active);
            if (rst_n) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input string name);
        int k;
        k = 0;
        while (period_tick !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        total++;
        if (period_tick !== 1'b1) begin
            bad++;
            $display("FAIL %s: period_tick timeout, got %b, expected 1", name, period_tick);
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            h += int'(pwm_out);
            cyc(1);
        end
    endtask

    logic [7:0] pat;
    int         h;

    initial begin
        rst_n = 1'b0; run = 1'b0; presc_div = 4'd0; duty_in = 3'd0; duty_wr = 1'b0;
        cyc(2);
        check("rst_cnt", int'(cnt), 0);
        check("rst_dec_en", int'(dec_en), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_duty_active", int'(duty_active), 0);
        rst_n = 1'b1;

        // 1: duty 3, divide-by-1 -> 1,1,1,0,0,0,0,0
        duty_in = 3'd3; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0; run = 1'b1;
        cyc(1);
        pat = 8'b1110_0000;
        for (int i = 0; i < 8; i++) begin
            check("t1_pwm_pattern", int'(pwm_out), int'(pat[7-i]));
            cyc(1);
        end
        check("t1_tick_after_8", int'(period_tick), 1);
        check("t1_dec_en", int'(dec_en), 1);
        check("t1_duty_active", int'(duty_active), 3);

        // 2: divide-by-2, duty 5 -> 16 clk period, 10 high
        presc_div = 4'd1; duty_in = 3'd5; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0;
        wait_tick("t2_wait");
        check("t2_duty_active", int'(duty_active), 5);
        h = 0;
        for (int i = 0; i < 16; i++) begin
            check("t2_cnt_hold", int'(cnt), i / 2);
            h += int'(pwm_out);
            cyc(1);
        end
        check("t2_high_count", h, 10);
        check("t2_tick_after_16", int'(period_tick), 1);

        // 3: duty 2 running, write 6 at cnt=3 -> applies next period
        presc_div = 4'd0; duty_in = 3'd2; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0;
        wait_tick("t3_wait");
        check("t3_duty_active_2", int'(duty_active), 2);
        cyc(3);
        check("t3_cnt3", int'(cnt), 3);
        duty_in = 3'd6; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0;
        cyc(3);
        check("t3_cnt7_active_old", int'(duty_active), 2);
        cyc(1);
        check("t3_wrap_cnt", int'(cnt), 0);
        check("t3_wrap_active_new", int'(duty_active), 6);
        count_high(8, h);
        check("t3_next_period_high", h, 6);

        // 4: write 4 on the wrap edge -> old duty next period, 4 after
        cyc(7);
        check("t4_cnt7", int'(cnt), 7);
        duty_in = 3'd4; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0;
        check("t4_no_bypass", int'(duty_active), 6);
        count_high(8, h);
        check("t4_old_period_high", h, 6);
        check("t4_new_active", int'(duty_active), 4);
        count_high(8, h);
        check("t4_new_period_high", h, 4);

        // 5: drop run at cnt=2 -> finish the period then idle
        cyc(2);
        check("t5_cnt2", int'(cnt), 2);
        run = 1'b0;
        cyc(1);
        check("t5_stop_pend_dec_en", int'(dec_en), 1);
        cyc(4);
        check("t5_cnt7", int'(cnt), 7);
        cyc(1);
        check("t5_idle_cnt", int'(cnt), 0);
        check("t5_idle_dec_en", int'(dec_en), 0);
        check("t5_idle_pwm", int'(pwm_out), 0);
        check("t5_idle_tick", int'(period_tick), 1);
        cyc(3);
        check("t5_idle_hold", int'(cnt), 0);
        // re-raise during STOP_PEND: no gap, no restart
        run = 1'b1;
        cyc(1);
        check("t5_restart_dec_en", int'(dec_en), 1);
        cyc(2);
        run = 1'b0;
        cyc(3);
        check("t5_pend_cnt5", int'(cnt), 5);
        run = 1'b1;
        cyc(3);
        check("t5_resume_cnt", int'(cnt), 0);
        check("t5_resume_dec_en", int'(dec_en), 1);
        cyc(1);
        check("t5_resume_counts_on", int'(cnt), 1);

        // 6: async reset mid-period with pwm high
        duty_in = 3'd7; duty_wr = 1'b1;
        cyc(1);
        duty_wr = 1'b0;
        wait_tick("t6_wait");
        cyc(4);
        check("t6_pre_cnt", int'(cnt), 4);
        check("t6_pre_pwm", int'(pwm_out), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_cnt", int'(cnt), 0);
        check("t6_async_dec_en", int'(dec_en), 0);
        check("t6_async_pwm", int'(pwm_out), 0);
        check("t6_async_tick", int'(period_tick), 0);
        check("t6_async_active", int'(duty_active), 0);
        run = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("t6_post_idle", int'(dec_en), 0);
        run = 1'b1;
        cyc(1);
        check("t6_run_dec_en", int'(dec_en), 1);
        check("t6_run_active", int'(duty_active), 0);
        count_high(8, h);
        check("t6_pwm_const0", h, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
